voxel_scene_scheduler: RTL
==========================

# voxel_scene_scheduler

Frame-level sequencer that walks a voxel occupancy memory and issues one `cube_drawer` job per occupied voxel. It sits between the frame controller and the cube drawer. It latches the view matrix once per frame and converts voxel indices into Q16.16 corner coordinates centred on the origin. It reports frame completion and the number of cubes drawn.

## Interface
Parameters:
- `COORD_WIDTH`, 32: width of signed Q16.16 coordinates and matrix entries.
- `GRID_X`, 8: voxels along x (power of two).
- `GRID_Y`, 8: voxels along y (power of two).
- `GRID_Z`, 8: voxels along z (power of two).
- `MEM_LATENCY`, 2: cycles from `voxel_addr` to valid `voxel_data`; legal range 1–3.
- `ADDR_WIDTH`, $clog2(GRID_X*GRID_Y*GRID_Z): voxel address width.

Ports:
- Reset: already decided. One clock; reset is asynchronous and active-high.
- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: asynchronous active-high reset.
- `frame_start`, in, 1: single-cycle request to draw one frame.
- `view_matrix_in`, in, 4x4xCOORD_WIDTH signed: camera matrix, sampled on an accepted `frame_start`.
- `voxel_addr`, out, ADDR_WIDTH: occupancy memory read address.
- `voxel_data`, in, 1: occupancy bit, valid MEM_LATENCY cycles after the address.
- `cube_start`, out, 1: single-cycle start pulse to the cube drawer.
- `cube_x`, `cube_y`, `cube_z`, out, COORD_WIDTH signed each: cube corner.
- `view_matrix`, out, 4x4xCOORD_WIDTH signed: latched matrix, held stable for the whole frame.
- `cube_busy`, in, 1: cube drawer busy.
- `cube_done`, in, 1: cube drawer done pulse.
- `busy`, out, 1: a frame is in progress.
- `frame_done`, out, 1: single-cycle pulse at the end of a frame.
- `cube_count`, out, ADDR_WIDTH+1: occupied voxels drawn in the current or last frame.

## Operation
- **States:** IDLE, FETCH, WAIT_MEM, CHECK, START_CUBE, WAIT_CUBE, NEXT, DONE.
- **IDLE:** on `frame_start`:
  - latch `view_matrix_in`;
  - clear the x/y/z counters and `cube_count`;
  - set `busy`=1 and go to FETCH.
- **FETCH:** drive `voxel_addr` = z*GRID_X*GRID_Y + y*GRID_X + x (x fastest), then go to WAIT_MEM.
- **WAIT_MEM:** count MEM_LATENCY-1 cycles, then go to CHECK. `voxel_addr` is held through CHECK.
- **CHECK:** if `voxel_data`=1, go to START_CUBE; otherwise go to NEXT.
- **START_CUBE:**
  - drive `cube_x` = (x - GRID_X/2) << 16, and likewise for y and z;
  - pulse `cube_start` for exactly one cycle;
  - go to WAIT_CUBE.
- **WAIT_CUBE:** wait for `cube_done`, then increment `cube_count` and go to NEXT. Corner outputs are held until `cube_done`.
- **NEXT:**
  - increment x; on wrap to 0, increment y; on y wrap, increment z;
  - if the last voxel (GRID_X-1, GRID_Y-1, GRID_Z-1) was just processed, go to DONE; otherwise go to FETCH.
- **DONE:** pulse `frame_done` for one cycle, clear `busy`, return to IDLE.
- **Arithmetic:** corner arithmetic is signed and sign-extended to COORD_WIDTH. The cube width is fixed at 1.0 (0x0001_0000), matching the cube drawer.
- **Boundary conditions:**
  - `frame_start` while `busy` is ignored and not queued.
  - `cube_done` outside WAIT_CUBE is ignored.
  - `cube_count` is not cleared by DONE; it holds until the next accepted `frame_start`.
- **Reset:** on `rst_in` (asynchronous, any state) go to IDLE. All outputs read 0: `cube_start`, `busy`, `frame_done`, `cube_count`, `voxel_addr`, `cube_x`/`cube_y`/`cube_z`, and `view_matrix`. A cube job in flight is abandoned; the cube drawer shares `rst_in` and is cleared with it.

## Timing
- `frame_start` to first `voxel_addr`: 1 cycle (FETCH is entered in the next cycle).
- Empty voxel cost: 2 + MEM_LATENCY cycles (FETCH, WAIT_MEM, CHECK, NEXT).
- Occupied voxel cost: 4 + MEM_LATENCY cycles plus the drawer time.
- `cube_start` is asserted only when the drawer is idle. It is never issued sooner than 2 cycles after the previous `cube_done`, because NEXT and FETCH always intervene. This matches the drawer's DONE→IDLE turnaround.
- `frame_done` asserts 2 cycles after the last voxel's CHECK or `cube_done`; `busy` falls in the same cycle.
- Empty frame, defaults (512 voxels, latency 2): 512*4 + 2 = 2050 cycles from `frame_start` to `frame_done`.

## Structure
- **Shared package `scene_pkg`:**
  - Q16.16 constants: `FIX_ONE` = 32'h0001_0000, `FIX_SHIFT` = 16;
  - the `mat4_t` typedef (4x4 signed COORD_WIDTH);
  - the state enum.
- **Sub-module `voxel_index_counter`:** 3-axis wrap counter with `step`, `clear`, outputs x/y/z, linear address and `last`. It is reusable by future per-voxel passes (e.g. occlusion).

## Test plan
- Empty map, defaults: `frame_start` → 2050 cycles, no `cube_start`, `frame_done` pulse, `cube_count`=0.
- Only voxel (0,0,0) set, drawer model with done after 20 cycles: exactly one `cube_start` with corner (-0x0004_0000, -0x0004_0000, -0x0004_0000); `cube_count`=1.
- Voxels (7,7,7) and (1,0,0) set: starts in address order — (1,0,0) first with `cube_x`=-0x0003_0000, then (7,7,7) with corner 0x0003_0000 on each axis; each `cube_start` is ≥2 cycles after the prior `cube_done`.
- `frame_start` pulsed mid-frame with a different matrix: ignored; `view_matrix` is unchanged until the next frame is accepted.
- `rst_in` asserted during WAIT_CUBE: all outputs go to 0 immediately (asynchronously); a later `frame_start` runs a full, correct frame.
- MEM_LATENCY=1 and MEM_LATENCY=3 with a full map: 512 cubes drawn, `cube_count`=512, the correct voxel sampled each time (the memory model returns address parity).

Source files
------------

// File: rtl/scene_pkg.sv
// Shared definitions for the voxel scene pipeline: Q16.16 fixed-point
// constants, the 4x4 view matrix type and the scheduler state encoding.
package scene_pkg;

    localparam int SCENE_COORD_W = 32;
    localparam int FIX_SHIFT     = 16;
    localparam logic [SCENE_COORD_W-1:0] FIX_ONE = 32'h0001_0000;

    // Row-major 4x4 matrix of signed Q16.16 entries.
    typedef logic signed [3:0][3:0][SCENE_COORD_W-1:0] mat4_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        CHECK,
        START_CUBE,
        WAIT_CUBE,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/voxel_index_counter.sv
// Three-axis wrap counter over a power-of-two voxel grid. x runs fastest,
// then y, then z. The linear address is the plain bit concatenation
// {z, y, x}, which equals z*GRID_X*GRID_Y + y*GRID_X + x for
// power-of-two grid sizes.
module voxel_index_counter
    import scene_pkg::*;
#(
    parameter int GRID_X     = 8,
    parameter int GRID_Y     = 8,
    parameter int GRID_Z     = 8,
    parameter int ADDR_WIDTH = $clog2(GRID_X * GRID_Y * GRID_Z),
    parameter int XW         = $clog2(GRID_X),
    parameter int YW         = $clog2(GRID_Y),
    parameter int ZW         = $clog2(GRID_Z)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear,
    input  logic                  step,
    output logic [XW-1:0]         x,
    output logic [YW-1:0]         y,
    output logic [ZW-1:0]         z,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic x_wrap;
    logic y_wrap;
    logic z_wrap;

    assign x_wrap = (x == XW'(GRID_X - 1));
    assign y_wrap = (y == YW'(GRID_Y - 1));
    assign z_wrap = (z == ZW'(GRID_Z - 1));

    assign addr = ADDR_WIDTH'({z, y, x});
    assign last = x_wrap & y_wrap & z_wrap;

    // Advance x, carrying into y and then z; clear has priority over step.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x <= '0;
            y <= '0;
            z <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
            z <= '0;
        end else if (step) begin
            x <= x_wrap ? '0 : x + 1'b1;
            if (x_wrap) begin
                y <= y_wrap ? '0 : y + 1'b1;
                if (y_wrap) begin
                    z <= z_wrap ? '0 : z + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/voxel_scene_scheduler.sv
// Frame sequencer: walks the voxel occupancy memory in address order and
// launches one cube drawer job per occupied voxel, with the view matrix
// latched for the whole frame.
module voxel_scene_scheduler
    import scene_pkg::*;
#(
    parameter int COORD_WIDTH = 32,
    parameter int GRID_X      = 8,
    parameter int GRID_Y      = 8,
    parameter int GRID_Z      = 8,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_WIDTH  = $clog2(GRID_X * GRID_Y * GRID_Z)
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      frame_start,
    input  logic signed [3:0][3:0][COORD_WIDTH-1:0]   view_matrix_in,
    output logic [ADDR_WIDTH-1:0]                     voxel_addr,
    input  logic                                      voxel_data,
    output logic                                      cube_start,
    output logic signed [COORD_WIDTH-1:0]             cube_x,
    output logic signed [COORD_WIDTH-1:0]             cube_y,
    output logic signed [COORD_WIDTH-1:0]             cube_z,
    output logic signed [3:0][3:0][COORD_WIDTH-1:0]   view_matrix,
    input  logic                                      cube_busy,
    input  logic                                      cube_done,
    output logic                                      busy,
    output logic                                      frame_done,
    output logic [ADDR_WIDTH:0]                       cube_count
);

    localparam int XW = $clog2(GRID_X);
    localparam int YW = $clog2(GRID_Y);
    localparam int ZW = $clog2(GRID_Z);

    state_t state;
    state_t state_nx;

    logic [1:0]            lat_cnt;
    logic                  frame_accept;
    logic [XW-1:0]         idx_x;
    logic [YW-1:0]         idx_y;
    logic [ZW-1:0]         idx_z;
    logic [ADDR_WIDTH-1:0] idx_addr;
    logic                  idx_last;

    // Voxel index to origin-centred Q16.16 corner: (idx - half) << 16,
    // computed signed so the lower half of the grid comes out negative.
    function automatic logic signed [COORD_WIDTH-1:0] voxel_corner(input int idx,
                                                                   input int half);
        logic signed [COORD_WIDTH-1:0] offs;
        offs = COORD_WIDTH'(idx - half);
        return offs <<< FIX_SHIFT;
    endfunction

    // A frame is only taken from IDLE; requests while busy are dropped.
    assign frame_accept = (state == IDLE) && frame_start;
    assign voxel_addr   = idx_addr;

    voxel_index_counter #(
        .GRID_X     (GRID_X),
        .GRID_Y     (GRID_Y),
        .GRID_Z     (GRID_Z),
        .ADDR_WIDTH (ADDR_WIDTH),
        .XW         (XW),
        .YW         (YW),
        .ZW         (ZW)
    ) u_index (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (frame_accept),
        .step   (state == NEXT),
        .x      (idx_x),
        .y      (idx_y),
        .z      (idx_z),
        .addr   (idx_addr),
        .last   (idx_last)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Memory latency counter: restarts on every fetch, runs during WAIT_MEM.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lat_cnt <= '0;
        end else if (state == FETCH) begin
            lat_cnt <= '0;
        end else if (state == WAIT_MEM) begin
            lat_cnt <= lat_cnt + 2'd1;
        end
    end

    // Frame matrix, cube corner and drawn-cube count registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            view_matrix <= '0;
            cube_count  <= '0;
            cube_x      <= '0;
            cube_y      <= '0;
            cube_z      <= '0;
        end else begin
            if (frame_accept) begin
                view_matrix <= view_matrix_in;
                cube_count  <= '0;
            end
            if ((state == CHECK) && voxel_data) begin
                cube_x <= voxel_corner(int'(idx_x), GRID_X / 2);
                cube_y <= voxel_corner(int'(idx_y), GRID_Y / 2);
                cube_z <= voxel_corner(int'(idx_z), GRID_Z / 2);
            end
            if ((state == WAIT_CUBE) && cube_done) begin
                cube_count <= cube_count + 1'b1;
            end
        end
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        cube_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                state_nx = (MEM_LATENCY == 1) ? CHECK : WAIT_MEM;
            end
            WAIT_MEM: begin
                if (int'(lat_cnt) >= MEM_LATENCY - 2) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = voxel_data ? START_CUBE : NEXT;
            end
            START_CUBE: begin
                // Guard against a drawer that is still busy; with a drawer
                // that honours its turnaround this launches immediately.
                if (!cube_busy) begin
                    cube_start = 1'b1;
                    state_nx   = WAIT_CUBE;
                end
            end
            WAIT_CUBE: begin
                if (cube_done) begin
                    state_nx = NEXT;
                end
            end
            NEXT: begin
                state_nx = idx_last ? DONE : FETCH;
            end
            DONE: begin
                busy       = 1'b0;
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
